// File: rtl/from_8bit_pkg.sv
// Shared constants for the 8/16/32-bit link receive side.
// Mode encodings and word widths used by the deserializer and its bench.
package from8bit_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_8    = 2'b00;
  localparam mode_t MODE_16   = 2'b01;
  localparam mode_t MODE_32   = 2'b10;
  localparam mode_t MODE_IDLE = 2'b11;

  localparam int W8  = 8;
  localparam int W16 = 16;
  localparam int W32 = 32;

endpackage

// File: rtl/from_8bit_if.sv
// Byte-stream bus between the link driver and the from_8bit deserializer.
// The master drives enable, byte and mode; the slave returns phases and words.
interface from_8bit_if;
  import from8bit_pkg::*;

  logic        enb;
  logic [7:0]  dataIn;
  mode_t       dataS;
  logic        clk10;
  logic        clk20;
  logic        clk40;
  logic [7:0]  dataOut;
  logic [15:0] dataOut16;
  logic [31:0] dataOut32;

  modport master (
    output enb, dataIn, dataS,
    input  clk10, clk20, clk40, dataOut, dataOut16, dataOut32
  );

  modport slave (
    input  enb, dataIn, dataS,
    output clk10, clk20, clk40, dataOut, dataOut16, dataOut32
  );

endinterface

// File: rtl/from_8bit_clk_div.sv
// Link clock divider: a free-running 3-bit counter whose bits are the
// clk/2, clk/4 and clk/8 slot phases shared with the paired transmitter.
module clk_div (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  output logic [2:0] cnt,
  output logic       clk10,
  output logic       clk20,
  output logic       clk40
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 3'd0;
    end else if (enb) begin
      cnt <= cnt + 3'd1;
    end
  end

  assign clk10 = cnt[0];
  assign clk20 = cnt[1];
  assign clk40 = cnt[2];

endmodule

// File: rtl/from_8bit.sv
// Byte-stream deserializer: republishes bytes or reassembles 16/32-bit words,
// emitting a word only when every earlier byte slot of it was captured.
module from_8bit
  import from8bit_pkg::*;
(
  input logic        clk,
  input logic        rst,
  from_8bit_if.slave bus
);

  logic [2:0]  cnt;
  logic        ph10, ph20, ph40;
  logic        capture;
  logic [1:0]  idx;
  logic        mode_chg;
  logic [3:0]  mask;
  logic [3:0]  base_mask;
  logic [3:0]  next_mask;
  logic [31:0] asm_buf;
  logic [7:0]  hi_byte;
  logic        half_ok;
  logic        word_ok;
  mode_t       prev_ds;
  logic [7:0]  out8;
  logic [15:0] out16;
  logic [31:0] out32;

  clk_div u_div (
    .clk   (clk),
    .rst   (rst),
    .enb   (bus.enb),
    .cnt   (cnt),
    .clk10 (ph10),
    .clk20 (ph20),
    .clk40 (ph40)
  );

  assign bus.clk10     = ph10;
  assign bus.clk20     = ph20;
  assign bus.clk40     = ph40;
  assign bus.dataOut   = out8;
  assign bus.dataOut16 = out16;
  assign bus.dataOut32 = out32;

  assign capture  = bus.enb && cnt[0] && (bus.dataS != MODE_IDLE);
  assign idx      = cnt[2:1];
  assign mode_chg = (bus.dataS != prev_ds);

  // A mode change or the first slot of a word starts a fresh mask, so a
  // partial word left over from another mode can never complete.
  always_comb begin
    base_mask = mask;
    if (mode_chg || (capture && idx == 2'd0)) begin
      base_mask = 4'd0;
    end
    next_mask = base_mask;
    if (capture) begin
      next_mask = base_mask | (4'b0001 << idx);
    end
  end

  assign hi_byte = idx[1] ? asm_buf[15:8] : asm_buf[31:24];
  assign half_ok = idx[1] ? base_mask[2] : base_mask[0];
  assign word_ok = (base_mask[2:0] == 3'b111);

  always_ff @(posedge clk) begin
    if (rst) begin
      mask    <= 4'd0;
      prev_ds <= MODE_8;
      asm_buf <= 32'd0;
      out8    <= 8'd0;
      out16   <= 16'd0;
      out32   <= 32'd0;
    end else if (bus.enb) begin
      prev_ds <= bus.dataS;
      mask    <= next_mask;
      if (capture) begin
        case (idx)
          2'd0:    asm_buf[31:24] <= bus.dataIn;
          2'd1:    asm_buf[23:16] <= bus.dataIn;
          2'd2:    asm_buf[15:8]  <= bus.dataIn;
          default: asm_buf[7:0]   <= bus.dataIn;
        endcase
        if (bus.dataS == MODE_8) begin
          out8 <= bus.dataIn;
        end
        if (bus.dataS == MODE_16 && idx[0] && half_ok) begin
          out16 <= {hi_byte, bus.dataIn};
        end
        if (bus.dataS == MODE_32 && idx == 2'd3 && word_ok) begin
          out32 <= {asm_buf[31:8], bus.dataIn};
        end
      end
    end
  end

endmodule

// File: tb/tb_from_8bit.sv
// Directed bench for from_8bit: stimulus queues expected values tagged with
// the cycle they apply to; a negedge monitor pops and compares them.
module tb_from_8bit;
  import from8bit_pkg::*;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   vectors;
  int   miscompares;
  exp_t sb[$];

  from_8bit_if bus ();

  from_8bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [31:0] actualOf(int sel);
    case (sel)
      0:       return {24'd0, bus.dataOut};
      1:       return {16'd0, bus.dataOut16};
      2:       return bus.dataOut32;
      default: return {29'd0, bus.clk40, bus.clk20, bus.clk10};
    endcase
  endfunction

  // Monitor: compares every expectation whose cycle has come due.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      act = actualOf(e.sel);
      vectors = vectors + 1;
      if (e.cyc < cyc) begin
        miscompares = miscompares + 1;
        $display("[TB] FAIL %s: missed check cycle %0d, got %h, want %h", e.name, e.cyc, act, e.val);
      end else if (act !== e.val) begin
        miscompares = miscompares + 1;
        $display("[TB] FAIL %s: got %h, want %h", e.name, act, e.val);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input int sel, input logic [31:0] val, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.sel  = sel;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    bus.dataIn = b;
    tick(2);
  endtask

  task automatic checkAll(input logic [7:0] v8, input logic [15:0] v16,
                          input logic [31:0] v32, input string tag);
    checkOutput(0, {24'd0, v8}, {tag, "_dataOut"});
    checkOutput(1, {16'd0, v16}, {tag, "_dataOut16"});
    checkOutput(2, v32, {tag, "_dataOut32"});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.enb     = 1'b0;
    bus.dataIn  = 8'h00;
    bus.dataS   = MODE_IDLE;
    tick(8);
    checkAll(8'h00, 16'h0000, 32'h0, "reset");
    checkOutput(3, 32'd0, "reset_phase");

    // Divider: phases count up from 0 with periods 2/4/8.
    rst       = 1'b0;
    bus.enb   = 1'b1;
    bus.dataS = MODE_8;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      checkOutput(3, i % 8, "phase");
    end

    // 8-bit mode.
    applyStimulus(8'h49); checkOutput(0, 32'h49, "m8_b0");
    applyStimulus(8'h76); checkOutput(0, 32'h76, "m8_b1");
    applyStimulus(8'hdf); checkOutput(0, 32'hdf, "m8_b2");
    applyStimulus(8'h00);
    checkAll(8'h00, 16'h0000, 32'h0, "m8_end");

    // 16-bit mode.
    bus.dataS = MODE_16;
    applyStimulus(8'h6b); applyStimulus(8'h57);
    checkOutput(1, 32'h6b57, "m16_w0");
    applyStimulus(8'h93); applyStimulus(8'h17);
    checkOutput(1, 32'h9317, "m16_w1");
    checkOutput(0, 32'h00, "m16_dataOut_hold");

    // 32-bit mode.
    bus.dataS = MODE_32;
    applyStimulus(8'h52); applyStimulus(8'hd5); applyStimulus(8'ha8); applyStimulus(8'hf9);
    checkOutput(2, 32'h52d5a8f9, "m32_w0");
    applyStimulus(8'h01); applyStimulus(8'hc5); applyStimulus(8'h91); applyStimulus(8'h11);
    checkOutput(2, 32'h01c59111, "m32_w1");
    checkOutput(1, 32'h9317, "m32_16_hold");

    // Mode change 01 -> 10 at cnt=4: partial word is dropped.
    bus.dataS = MODE_16;
    applyStimulus(8'h11); applyStimulus(8'h22);
    checkOutput(1, 32'h1122, "chg_m16");
    checkOutput(3, 32'd4, "chg_phase4");
    bus.dataS = MODE_32;
    applyStimulus(8'h33); applyStimulus(8'h44);
    checkAll(8'h00, 16'h1122, 32'h01c59111, "chg_partial");
    applyStimulus(8'haa); applyStimulus(8'hbb); applyStimulus(8'hcc); applyStimulus(8'hdd);
    checkOutput(2, 32'haabbccdd, "chg_full");

    // Idle: everything holds.
    bus.dataS = MODE_IDLE;
    for (int i = 0; i < 4; i++) applyStimulus(8'hee);
    checkAll(8'h00, 16'h1122, 32'haabbccdd, "idle");

    // Enable dropped for 5 clks after byte index 1.
    bus.dataS = MODE_32;
    applyStimulus(8'h12); applyStimulus(8'h34);
    bus.enb    = 1'b0;
    bus.dataIn = 8'hff;
    tick(5);
    checkOutput(3, 32'd4, "enb_phase_hold");
    checkOutput(2, 32'haabbccdd, "enb_hold");
    bus.enb = 1'b1;
    applyStimulus(8'h56); applyStimulus(8'h78);
    checkOutput(2, 32'h12345678, "enb_word");

    // Reset at byte index 2 discards the partial word.
    applyStimulus(8'h9a); applyStimulus(8'hbc);
    rst = 1'b1;
    tick(2);
    checkAll(8'h00, 16'h0000, 32'h0, "rst_mid");
    checkOutput(3, 32'd0, "rst_mid_phase");
    rst = 1'b0;
    applyStimulus(8'hde); applyStimulus(8'hf0);
    checkOutput(2, 32'h0, "rst_no_stale");
    applyStimulus(8'h03); applyStimulus(8'h04);
    checkOutput(2, 32'hdef00304, "rst_next_word");

    tick(2);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors     = vectors + 1;
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: never checked, got %h, want %h", e.name, actualOf(e.sel), e.val);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/from_8bit.md
# from_8bit

Byte-stream deserializer for the receive side of the 8/16/32-bit link. It takes one byte per byte slot on `dataIn` and, depending on `dataS`, republishes it as an 8-bit word or reassembles consecutive bytes into 16-bit or 32-bit words. It also contains the link's clock divider and exports the divided phase signals (clk/2, clk/4, clk/8), which define byte, half-word and word slot boundaries for the paired transmitter.

## Interface
Parameters: none.

- `clk` — in, 1. Single system clock; all state updates on its rising edge.
- `rst` — in, 1. Synchronous, active-high reset.
- `enb` — in, 1. Enable; when low, all state freezes.
- `dataIn` — in, 8. Incoming byte.
- `dataS` — in, 2. Mode select:
  - 00: 8-bit
  - 01: 16-bit
  - 10: 32-bit
  - 11: idle
- `clk10` — out, 1. clk/2 phase (`cnt[0]`).
- `clk20` — out, 1. clk/4 phase (`cnt[1]`).
- `clk40` — out, 1. clk/8 phase (`cnt[2]`).
- `dataOut` — out, 8. Last byte received in 8-bit mode.
- `dataOut16` — out, 16. Last assembled 16-bit word.
- `dataOut32` — out, 32. Last assembled 32-bit word.

## Operation
- **Divider.** 3-bit counter `cnt` increments by 1 (mod 8) on every clk with `enb`=1 and holds otherwise. `clk10`/`clk20`/`clk40` are `cnt[0]`/`cnt[1]`/`cnt[2]` directly (registered, glitch-free).
- **Byte capture.** A capture occurs on a clk edge with `enb`=1, `cnt[0]`=1 and `dataS`≠11. Byte index = `cnt[2:1]`.
- **Mode 00.** `dataOut` ← `dataIn` at every capture.
- **Mode 01.** The byte at `cnt[1]`=0 is stored as the high byte. At `cnt[1]`=1, `dataOut16` ← {high byte, `dataIn`}.
- **Mode 10.** Byte indices 0..3 map to bits [31:24], [23:16], [15:8], [7:0]. At index 3, `dataOut32` ← {b0, b1, b2, `dataIn`}.
- **Mode 11.** No captures; all outputs hold.
- **Inactive-mode outputs.** Outputs of the modes not selected hold their last value.
- **Valid mask.** A 4-bit mask marks which byte slots of the current word were captured in the current mode.
  - The mask clears at index 0 of each word.
  - The mask also clears whenever `dataS` differs from its registered previous value.
  - A 16/32-bit output updates only if all earlier slots of that word are marked. Partial words after a mode change are dropped, never emitted.
- **Reset.** Clears `cnt`, assembly buffer, mask, previous-`dataS` register and every output to 0. Reset takes priority over `enb`.

## Timing
- Byte slot: 2 clks; half-word: 4 clks; word: 8 clks. All slots are aligned to `cnt`=0.
- `clk10` rises on the edge where `cnt` becomes odd. Capture happens on the following edge, while `cnt[0]`=1.
- Latency:
  - `dataOut`: visible 1 clk after the capture edge decision, i.e. updated on the capture edge itself.
  - `dataOut16`: updated on the `cnt`=3 or `cnt`=7 capture edge.
  - `dataOut32`: updated on the `cnt`=7 capture edge.
- First full word after reset release: bytes at `cnt`=1,3,5,7 yield `dataOut32` on the 8th enabled clk.
- `enb` low mid-word: the counter and mask hold; assembly resumes when `enb` returns.
- `rst` mid-word: the partial word is discarded; the next word starts at `cnt`=0.
- `dataS` change takes effect at the next capture. The first word in the new mode starts at the next aligned boundary.

## Structure
- Package `from8bit_pkg`: mode constants `MODE_8`=2'b00, `MODE_16`=2'b01, `MODE_32`=2'b10, `MODE_IDLE`=2'b11, plus width constants 8/16/32.
- Sub-module `clk_div`:
  - Inputs: `clk`, `rst`, `enb`.
  - Outputs: `cnt[2:0]` and the three phase bits.
- The remaining logic lives in the top: capture decode, assembly buffer, mask, and output registers.

## Test plan
- **Reset/divider.** Hold `rst` 8 clks → all outputs 0. Release with `enb`=1 → `clk10`/`clk20`/`clk40` have periods of 2/4/8 clks, all starting low.
- **8-bit mode.** `dataS`=00; drive 0x49, 0x76, 0xdf in successive byte slots → `dataOut` = 0x49, 0x76, 0xdf on successive capture edges. `dataOut16` and `dataOut32` stay 0.
- **16-bit mode.** `dataS`=01; bytes 6b,57 then 93,17 → `dataOut16` = 0x6b57 at `cnt`=3, then 0x9317 at `cnt`=7.
- **32-bit mode.** `dataS`=10; bytes 52,d5,a8,f9 then 01,c5,91,11 → `dataOut32` = 0x52d5a8f9, then 0x01c59111 at successive `cnt`=7 edges.
- **Mode change / idle.** Switch `dataS` 01→10 at `cnt`=4 → no `dataOut32` update until a full aligned word is captured. `dataS`=11 → all outputs hold.
- **Enable/reset mid-word.** Drop `enb` for 5 clks after byte index 1 of a 32-bit word → the word still assembles correctly. Assert `rst` at index 2 → all outputs 0 and no stale word is emitted.
